// File: rtl/program_loader.sv
// program_loader: assembles a little-endian byte stream into instruction words, writes them to instruction memory, then releases the CPU
module program_loader #(
    parameter int WIDTH = 32,
    parameter int SIZE = 64,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    input  logic                 byte_last,
    output logic                 byte_ready,
    output logic [WIDTH-1:0]     instr_in,
    output logic [LOGSIZE+1:0]   instr_wr_addr,
    output logic                 instr_wr_en,
    output logic                 cpu_reset,
    output logic                 load_done,
    output logic                 load_error,
    output logic [LOGSIZE:0]     word_count
);
    localparam int NB = WIDTH / 8;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
    localparam logic [1:0] LOAD = 2'd0, WRITE = 2'd1, DONE = 2'd2, ERROR = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [LOGSIZE:0]   word_count_q, word_count_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               last_q, last_d;
    logic               accept, in_write;

    // byte_ready and the write strobe are gated by reset so nothing is accepted or written while held in reset
    assign byte_ready    = reset && state_q == LOAD;
    assign accept        = byte_ready && byte_valid;
    assign in_write      = reset && state_q == WRITE;
    assign instr_wr_en   = in_write;
    assign instr_in      = in_write ? word_q : '0;
    assign instr_wr_addr = in_write ? {word_count_q[LOGSIZE-1:0], 2'b00} : '0;
    assign cpu_reset     = state_q != DONE;
    assign load_done     = state_q == DONE;
    assign load_error    = state_q == ERROR;
    assign word_count    = word_count_q;

    // next-state: lane assembly in LOAD, single-cycle write with count update in WRITE; DONE/ERROR hold
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        word_count_d = word_count_q;
        word_d = word_q;
        last_d = last_q;
        if (accept) begin
            word_d[8*idx_q +: 8] = byte_in;
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(NB - 1)) begin
                idx_d = '0;
                last_d = byte_last;
                state_d = WRITE;
            end else if (byte_last) begin
                state_d = ERROR;
            end
        end else if (state_q == WRITE) begin
            word_count_d = word_count_q + (LOGSIZE+1)'(1);
            state_d = last_q ? DONE : (word_count_d == (LOGSIZE+1)'(SIZE)) ? ERROR : LOAD;
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LOAD;
            idx_q <= '0;
            word_count_q <= '0;
            word_q <= '0;
            last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            word_count_q <= word_count_d;
            word_q <= word_d;
            last_q <= last_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed stimulus with a write scoreboard for program_loader
module tb_program_loader;
    logic clk = 0;
    always #5 clk = ~clk;

    logic       reset = 0;
    logic [7:0] byte_in = 0;
    logic       byte_valid = 0, byte_last = 0, sel4 = 0;
    logic       v_main, v4;
    assign v_main = byte_valid && !sel4;
    assign v4 = byte_valid && sel4;

    logic        byte_ready, instr_wr_en, cpu_reset, load_done, load_error;
    logic [31:0] instr_in;
    logic [7:0]  instr_wr_addr;
    logic [6:0]  word_count;
    logic        byte_ready_4, instr_wr_en_4, cpu_reset_4, load_done_4, load_error_4;
    logic [31:0] instr_in_4;
    logic [3:0]  instr_wr_addr_4;
    logic [2:0]  word_count_4;

    program_loader #(.WIDTH(32), .SIZE(64)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(v_main), .byte_last(byte_last),
        .byte_ready(byte_ready), .instr_in(instr_in), .instr_wr_addr(instr_wr_addr),
        .instr_wr_en(instr_wr_en), .cpu_reset(cpu_reset), .load_done(load_done),
        .load_error(load_error), .word_count(word_count)
    );

    program_loader #(.WIDTH(32), .SIZE(4)) dut4 (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(v4), .byte_last(byte_last),
        .byte_ready(byte_ready_4), .instr_in(instr_in_4), .instr_wr_addr(instr_wr_addr_4),
        .instr_wr_en(instr_wr_en_4), .cpu_reset(cpu_reset_4), .load_done(load_done_4),
        .load_error(load_error_4), .word_count(word_count_4)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    typedef struct {
        int          addr;
        logic [31:0] data;
        int          c;
    } exp_t;
    exp_t q[$], q4[$];
    exp_t em, em4;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every write strobe is matched against the scoreboard; the bus must be zero otherwise
    always @(negedge clk) begin
        if (instr_wr_en) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", instr_wr_addr, instr_in);
            end else begin
                em = q.pop_front();
                check("wr_addr", instr_wr_addr, em.addr);
                check("wr_data", instr_in, em.data);
                check("wr_latency", cyc, em.c);
            end
        end else begin
            check("idle_bus", {instr_in, instr_wr_addr}, 0);
        end
        if (instr_wr_en_4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write4: got addr %0h data %0h expected no write", instr_wr_addr_4, instr_in_4);
            end else begin
                em4 = q4.pop_front();
                check("wr4_addr", instr_wr_addr_4, em4.addr);
                check("wr4_data", instr_in_4, em4.data);
                check("wr4_latency", cyc, em4.c);
            end
        end else begin
            check("idle_bus4", {instr_in_4, instr_wr_addr_4}, 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 0;
            byte_last = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, output int acc_cyc, output int stalls);
        int n;
        n = 0;
        @(negedge clk);
        byte_in = b;
        byte_last = last;
        byte_valid = 1;
        while (!(sel4 ? byte_ready_4 : byte_ready)) begin
            n++;
            if (n > 20) begin
                errors++;
                $display("FAIL send_timeout: got no byte_ready expected within 20 cycles");
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "byte_ready timeout");
            end
            @(negedge clk);
        end
        acc_cyc = cyc + 1;
        stalls = n;
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int addr, input logic last, input int gap,
                             output int first_stall);
        int ac, st;
        exp_t e;
        first_stall = 0;
        for (int i = 0; i < 4; i++) begin
            if (gap > 0) idle(gap);
            send_byte(w[8*i +: 8], last && i == 3, ac, st);
            if (i == 0) first_stall = st;
        end
        e.addr = addr;
        e.data = w;
        e.c = ac;
        if (sel4) q4.push_back(e);
        else q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        byte_valid = 0;
        byte_last = 0;
        @(negedge clk);
        check("rst_ready", byte_ready, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done_err", {load_done, load_error}, 0);
        check("rst_word_count", word_count, 0);
        check("rst_wr_en", instr_wr_en, 0);
        reset = 1;
    endtask

    task automatic send_three(input int gap);
        int st;
        send_word(32'h11223344, 0, 0, gap, st);
        if (gap == 0) check("w0_stall", st, 0);
        send_word(32'hA5A55A5A, 4, 0, gap, st);
        if (gap == 0) check("w1_stall", st, 1);
        send_word(32'hDEADBEEF, 8, 1, gap, st);
        if (gap == 0) check("w2_stall", st, 1);
        idle(2);
        check("three_wc", word_count, 3);
        check("three_done", {load_done, cpu_reset, load_error}, 3'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, ac;
        do_reset();
        @(negedge clk);
        check("post_rst_ready", byte_ready, 1);
        check("post_rst_cpu_reset", cpu_reset, 1);

        send_word(32'h00500093, 0, 1, 0, st);
        idle(2);
        check("single_done", load_done, 1);
        check("single_cpu_reset", cpu_reset, 0);
        check("single_wc", word_count, 1);
        check("single_ready", byte_ready, 0);
        @(negedge clk);
        byte_in = 8'h55;
        byte_valid = 1;
        repeat (3) @(negedge clk);
        check("done_hold_wc", word_count, 1);
        check("done_hold", load_done, 1);
        idle(1);

        do_reset();
        send_three(0);

        do_reset();
        send_word(32'h01020304, 0, 0, 0, st);
        send_byte(8'hAA, 0, ac, st);
        send_byte(8'hBB, 1, ac, st);
        idle(1);
        check("err_flag", load_error, 1);
        check("err_cpu_reset", cpu_reset, 1);
        check("err_ready", byte_ready, 0);
        check("err_wc", word_count, 1);
        check("err_done", load_done, 0);
        idle(3);
        check("err_hold", load_error, 1);

        do_reset();
        sel4 = 1;
        send_word(32'h04030201, 0, 0, 0, st);
        send_word(32'h08070605, 4, 0, 0, st);
        send_word(32'h0C0B0A09, 8, 0, 0, st);
        send_word(32'h100F0E0D, 12, 0, 0, st);
        idle(2);
        check("ovf_error", load_error_4, 1);
        check("ovf_wc", word_count_4, 4);
        check("ovf_ready", byte_ready_4, 0);
        check("ovf_cpu_reset", cpu_reset_4, 1);
        sel4 = 0;

        do_reset();
        send_three(2);

        do_reset();
        send_byte(8'hAA, 0, ac, st);
        send_byte(8'hBB, 0, ac, st);
        do_reset();
        send_word(32'h12345678, 0, 1, 0, st);
        idle(2);
        check("midrst_wc", word_count, 1);
        check("midrst_done", load_done, 1);

        do_reset();
        idle(10);
        check("empty_ready", byte_ready, 1);
        check("empty_cpu_reset", cpu_reset, 1);
        check("empty_done", {load_done, load_error}, 0);
        check("empty_wc", word_count, 0);

        idle(2);
        check("sb_empty", q.size(), 0);
        check("sb4_empty", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
